// File: rtl/ghash_digit_serial_core_if.sv
// Block/key handshake bundle between the GCM framing logic and the GHASH core.
interface ghash_digit_serial_core_if #(
    parameter int NB_DATA = 128
);
    logic               i_valid_key;
    logic [NB_DATA-1:0] i_key_h;
    logic               i_valid;
    logic [NB_DATA-1:0] i_data;
    logic               i_sop;
    logic               i_eop;
    logic               o_ready;
    logic               o_valid;
    logic               o_last;
    logic [NB_DATA-1:0] o_ghash;

    modport master (
        output i_valid_key, i_key_h, i_valid, i_data, i_sop, i_eop,
        input  o_ready, o_valid, o_last, o_ghash
    );

    modport slave (
        input  i_valid_key, i_key_h, i_valid, i_data, i_sop, i_eop,
        output o_ready, o_valid, o_last, o_ghash
    );
endinterface

// File: rtl/ghash_digit_serial_core.sv
// Digit-serial GHASH accumulator: Y_i = (Y_{i-1} ^ X_i) * H over GF(2^128),
// consuming NB_DIGIT multiplier bits per clock.
module ghash_digit_serial_core #(
    parameter int NB_DATA  = 128,
    parameter int NB_DIGIT = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    ghash_digit_serial_core_if.slave   bus
);
    // Unsupported geometry: the core never accepts a block.
    localparam bit BAD_CONF = (NB_DATA != 128) || (NB_DIGIT <= 0) ||
                              ((NB_DATA % NB_DIGIT) != 0);
    localparam int N_DIGITS = (NB_DIGIT > 0) ? NB_DATA / NB_DIGIT : 1;
    localparam int CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);
    // Reduction constant for x^128 + x^7 + x^2 + x + 1 in GCM bit order.
    localparam logic [NB_DATA-1:0] R = {8'he1, {(NB_DATA-8){1'b0}}};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [NB_DATA-1:0] h;
    logic [NB_DATA-1:0] acc;
    logic [NB_DATA-1:0] a_reg;
    logic [NB_DATA-1:0] z;
    logic [NB_DATA-1:0] v;
    logic [CNT_W-1:0]   cnt;
    logic               eop_flag;
    logic               valid_q;
    logic               last_q;
    logic [NB_DATA-1:0] ghash_q;
    logic [NB_DATA-1:0] z_next;
    logic [NB_DATA-1:0] v_next;

    // Key load has priority over a block, so ready drops while a key is offered.
    assign bus.o_ready = (state == IDLE) && !bus.i_valid_key && !BAD_CONF;
    assign bus.o_valid = valid_q;
    assign bus.o_last  = last_q;
    assign bus.o_ghash = ghash_q;

    // NB_DIGIT chained shift-and-add steps over the top bits of a_reg (MSB first).
    always_comb begin
        z_next = z;
        v_next = v;
        for (int i = 0; i < NB_DIGIT; i++) begin
            if (a_reg[NB_DATA-1-i])
                z_next = z_next ^ v_next;
            v_next = v_next[0] ? ((v_next >> 1) ^ R) : (v_next >> 1);
        end
    end

    // Control FSM and datapath registers; outputs are registered.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            h        <= '0;
            acc      <= '0;
            a_reg    <= '0;
            z        <= '0;
            v        <= '0;
            cnt      <= '0;
            eop_flag <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ghash_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_valid_key) begin
                        h <= bus.i_key_h;
                    end else if (bus.i_valid && !BAD_CONF) begin
                        a_reg    <= (bus.i_sop ? '0 : acc) ^ bus.i_data;
                        z        <= '0;
                        v        <= h;
                        cnt      <= '0;
                        eop_flag <= bus.i_eop;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    a_reg <= a_reg << NB_DIGIT;
                    z     <= z_next;
                    v     <= v_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        acc     <= z_next;
                        ghash_q <= z_next;
                        valid_q <= 1'b1;
                        last_q  <= eop_flag;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ghash_digit_serial_core.md
# ghash_digit_serial_core

Sequential GHASH engine for the AES-GCM datapath. It accumulates 128-bit blocks as Y_i = (Y_{i-1} xor X_i)·H over GF(2^128) and exposes the running hash. The multiplication is digit-serial: NB_DIGIT bits of the multiplier operand are consumed per clock, which trades the area of the fully combinational 128x128 multiplier for 128/NB_DIGIT cycles per block. It sits between the block-framing logic (AAD, ciphertext and length blocks) and the tag XOR stage.

## Interface
- NB_DATA, 128, block width; any other value sets BAD_CONF.
- NB_DIGIT, 8, bits of the multiplier operand processed per cycle. Must divide NB_DATA; otherwise BAD_CONF.
- i_clock  in  1  single clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_valid_key  in  1  load i_key_h into the H register.
- i_key_h  in  NB_DATA  hash subkey H.
- i_valid  in  1  input block valid.
- i_data  in  NB_DATA  input block X_i, GCM bit order (bit NB_DATA-1 = coefficient of x^0).
- i_sop  in  1  first block of a message; clears the accumulator before the XOR. Qualified by i_valid.
- i_eop  in  1  last block of a message (the length block). Qualified by i_valid.
- o_ready  out  1  core can accept a block.
- o_valid  out  1  one-cycle pulse: o_ghash updated with a new Y_i.
- o_last  out  1  asserted with o_valid when the finished block carried i_eop.
- o_ghash  out  NB_DATA  running accumulator Y_i.

## Operation
- Field and reduction:
  - R = {8'he1, 120'd0}.
  - Multiply Z = A·H, processing bits of A from bit NB_DATA-1 down to bit 0.
  - Per bit: if the A bit is 1, Z ^= V. Then V = V[0] ? (V>>1)^R : V>>1.
  - Start values: Z = 0, V = H.
  - NB_DIGIT such bit steps are chained combinationally in one cycle.
- States:
  - IDLE: o_ready = 1.
  - BUSY: o_ready = 0.
  - IDLE->BUSY when i_valid && o_ready.
  - BUSY->IDLE when the digit counter reaches NB_DATA/NB_DIGIT-1.
- On accept:
  - A_reg = (i_sop ? 0 : acc) ^ i_data.
  - Z = 0, V = H, counter = 0.
  - eop_flag = i_eop.
- Each BUSY cycle:
  - Consume the top NB_DIGIT bits of A_reg.
  - Shift A_reg left by NB_DIGIT.
  - Increment the counter.
- On the last BUSY cycle: acc <= final Z and o_ghash <= final Z. On the following cycle, o_valid = 1 and o_last = eop_flag for exactly one cycle.
- Key load:
  - i_valid_key is honoured only in IDLE and not in the same cycle as a block accept. If both are asserted, the key load wins and the block is not accepted: o_ready is low that cycle.
  - i_valid_key during BUSY is ignored; H stays stable for the whole multiplication.
- i_sop and i_eop may both be set, meaning a single-block message.
- Widths: all datapath registers are NB_DATA wide. The counter is clog2(NB_DATA/NB_DIGIT) bits, with a minimum of 1.

## Timing
- Reset values: o_ready = 1, o_valid = 0, o_last = 0, o_ghash = 0. acc, H, A_reg and the counter also reset to 0, and the state is IDLE.
- Latency:
  - A block accepted at clock edge T updates o_ghash at edge T + NB_DATA/NB_DIGIT (T+16 at the default).
  - o_valid is high in the cycle after that edge.
- Throughput: o_ready rises in the same cycle o_valid pulses. A back-to-back block can be accepted then, giving one block per NB_DATA/NB_DIGIT + 1 cycles (17 at the default).
- o_ghash holds its value between pulses.
- i_data, i_sop and i_eop are sampled only at accept. Changes while BUSY have no effect.
- Asynchronous reset mid-BUSY aborts the block immediately:
  - All registers return to their reset values, including H, so the key must be reloaded.
  - No o_valid is produced for the aborted block.

## Test plan
- Unity key:
  - Stimulus: load H = 0x8000…0, then one block with sop=eop=1, data 0x0123456789abcdeffedcba9876543210.
  - Required: at edge T+16, o_ghash = the same value; o_valid and o_last pulse for one cycle.
- Reduction:
  - Stimulus: H = 0x4000…0 (x), block 0x000…01 with sop=1.
  - Required: o_ghash = 0xe1000…0, showing the R fold.
- NIST GCM test case 2:
  - Stimulus: H = 66e94bd4ef8a2c3b884cfa59ca342b2e, block 0388dace60b6a392f328c2b971b2fe78 with sop=1.
  - Required: o_ghash = 5e2ec746917062882c85b0685353deb7.
  - Then feed length block 0…0080 with eop=1; o_ghash must match the bit-serial C model and o_last = 1.
- Back-to-back with sop restart:
  - Stimulus: two-block message, then a new sop block presented in the o_valid cycle.
  - Required: accepted with no bubble; the new result is independent of the prior accumulator; o_ready is low for exactly 16 cycles per block.
- Key/handshake corners:
  - i_valid_key pulsed during BUSY with a new H: the current result uses the old H.
  - i_valid_key and i_valid asserted together in IDLE: the key loads, the block is not accepted, and the block is accepted on the next cycle.
- Reset mid-operation:
  - Stimulus: assert i_reset at counter 7.
  - Required: the outputs go to their reset values asynchronously with no o_valid. After reloading the key, the unity-key test passes again.
